tdoa_counter: RTL and testbench

TDOA_COUNTER -- requirements
Module: tdoa_counter

---
 rtl/tdoa_counter.sv | 166 ++++++++++++++++
 tb/tb_tdoa_counter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/tdoa_counter.sv
// Arrival-time-difference counter for two threshold-comparator channels.
// Optional macro TDOA_GLITCH_FILTER_EN adds a 3-cycle stability filter after each synchronizer.
module tdoa_counter #(
    parameter logic [9:0]  MAX_CNT = 10'd1000,
    parameter logic [15:0] HOLDOFF = 16'd5000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mic_a,
    input  logic       mic_b,
    output logic [9:0] cntr,
    output logic       cntr_valid,
    output logic       first_b,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, WAIT_B, WAIT_A, HOLD} state_t;

    localparam logic [15:0] HOLD_LAST = (HOLDOFF == 16'd0) ? 16'd0 : HOLDOFF - 16'd1;

    function automatic logic [9:0] sat_inc(input logic [9:0] v);
        return (v == 10'h3FF) ? v : v + 10'd1;
    endfunction

    // Bit 0 = channel A, bit 1 = channel B throughout the front end.
    logic [1:0] sync_p0, sync_p1;
    logic [1:0] lvl, lvl_d, armed, edge_p2;
    logic [2:0] settle;
    logic       settled;

    // Stage p0/p1: two-flop synchronizer
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= 2'b00;
            sync_p1 <= 2'b00;
        end else begin
            sync_p0 <= {mic_b, mic_a};
            sync_p1 <= sync_p0;
        end
    end

`ifdef TDOA_GLITCH_FILTER_EN
    localparam logic [2:0] SETTLE_CYC = 3'd5;
    logic [1:0] hist0, hist1, filt;

    always_ff @(posedge clk) begin
        if (rst) begin
            hist0 <= 2'b00;
            hist1 <= 2'b00;
            filt  <= 2'b00;
        end else begin
            hist0 <= sync_p1;
            hist1 <= hist0;
            for (int i = 0; i < 2; i++) begin
                if (hist1[i] == hist0[i] && hist0[i] == sync_p1[i])
                    filt[i] <= sync_p1[i];
            end
        end
    end

    assign lvl = filt;
`else
    localparam logic [2:0] SETTLE_CYC = 3'd2;

    assign lvl = sync_p1;
`endif

    // Edges are only armed once a channel has been seen low after reset, so a
    // comparator already high at reset release cannot fake an arrival.
    assign settled = (settle == SETTLE_CYC);

    // Stage p2: registered rising-edge detector
    always_ff @(posedge clk) begin
        if (rst) begin
            settle  <= 3'd0;
            lvl_d   <= 2'b00;
            armed   <= 2'b00;
            edge_p2 <= 2'b00;
        end else begin
            if (!settled)
                settle <= settle + 3'd1;
            lvl_d   <= lvl;
            armed   <= armed | ({2{settled}} & ~lvl);
            edge_p2 <= lvl & ~lvl_d & armed;
        end
    end

    state_t      state, state_nxt;
    logic [9:0]  cnt, cnt_nxt;
    logic [15:0] hold_cnt, hold_nxt;
    logic [9:0]  cntr_nxt;
    logic        first_b_nxt, vld_nxt;
    logic        edge_a, edge_b;

    assign edge_a = edge_p2[0];
    assign edge_b = edge_p2[1];
    assign busy   = (state != IDLE);

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        hold_nxt    = hold_cnt;
        cntr_nxt    = cntr;
        first_b_nxt = first_b;
        vld_nxt     = 1'b0;
        case (state)
            IDLE: begin
                if (edge_a && edge_b) begin
                    cntr_nxt    = 10'd0;
                    first_b_nxt = 1'b0;
                    vld_nxt     = 1'b1;
                    hold_nxt    = 16'd0;
                    state_nxt   = HOLD;
                end else if (edge_a) begin
                    cnt_nxt   = 10'd1;
                    state_nxt = WAIT_B;
                end else if (edge_b) begin
                    cnt_nxt   = 10'd1;
                    state_nxt = WAIT_A;
                end
            end
            WAIT_B, WAIT_A: begin
                // The closing edge takes priority over the timeout on the same cycle.
                if ((state == WAIT_B) ? edge_b : edge_a) begin
                    cntr_nxt    = cnt;
                    first_b_nxt = (state == WAIT_A);
                    vld_nxt     = 1'b1;
                    hold_nxt    = 16'd0;
                    state_nxt   = HOLD;
                end else if (cnt >= MAX_CNT) begin
                    hold_nxt  = 16'd0;
                    state_nxt = HOLD;
                end else begin
                    cnt_nxt = sat_inc(cnt);
                end
            end
            HOLD: begin
                if (hold_cnt >= HOLD_LAST)
                    state_nxt = IDLE;
                else
                    hold_nxt = hold_cnt + 16'd1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Stage p3: FSM state and output register
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 10'd0;
            hold_cnt   <= 16'd0;
            cntr       <= 10'd0;
            first_b    <= 1'b0;
            cntr_valid <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            hold_cnt   <= hold_nxt;
            cntr       <= cntr_nxt;
            first_b    <= first_b_nxt;
            cntr_valid <= vld_nxt;
        end
    end

endmodule

// File: tb/tb_tdoa_counter.sv
// Self-checking bench for tdoa_counter: directed scenarios plus randomized arrival pairs
// checked against an arithmetic model of the expected measurement.
module tb_tdoa_counter;

    localparam int MAXC = 1000;
    localparam int HOLD = 300;
`ifdef TDOA_GLITCH_FILTER_EN
    localparam int LAT = 7;
`else
    localparam int LAT = 4;
`endif

    logic       clk = 1'b0;
    logic       rst, mic_a, mic_b;
    logic [9:0] cntr;
    logic       cntr_valid, first_b, busy;

    tdoa_counter #(.MAX_CNT(10'd1000), .HOLDOFF(16'd300)) dut (
        .clk(clk), .rst(rst), .mic_a(mic_a), .mic_b(mic_b),
        .cntr(cntr), .cntr_valid(cntr_valid), .first_b(first_b), .busy(busy)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   npulse, pcntr, pfb, pcyc, busy_n, ncons;
    logic prev_v;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic sample(input int c);
        if (cntr_valid === 1'b1) begin
            if (prev_v === 1'b1) ncons++;
            npulse++;
            pcntr = int'(cntr);
            pfb   = int'(first_b);
            pcyc  = c;
        end
        if (busy === 1'b1) busy_n++;
        prev_v = cntr_valid;
    endtask

    task automatic clear_stats();
        npulse = 0; busy_n = 0; ncons = 0; prev_v = 1'b0;
        pcntr = -1; pfb = -1; pcyc = -1;
    endtask

    task automatic wait_idle(input int c0);
        int c = c0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            sample(c);
            c++;
            if (busy === 1'b0) break;
        end
        chk("idle_reached", busy, 0);
        repeat (5) begin
            @(negedge clk);
            sample(c);
            c++;
        end
    endtask

    // tb < 0 means channel B never rises; glitch drops mic_a low for 5 cycles after its rise.
    task automatic run(input string tag, input int ta, input int tb, input bit glitch);
        int  last, d, busy_exp, c, cntr_before;
        bit  exp_v;
        cntr_before = int'(cntr);
        if (tb < 0) begin
            last = ta + 1100; d = MAXC + 1;
        end else begin
            last = (ta > tb) ? ta : tb;
            d    = (ta > tb) ? ta - tb : tb - ta;
        end
        exp_v    = (d <= MAXC);
        busy_exp = ((d < MAXC) ? d : MAXC) + HOLD;
        clear_stats();
        for (c = 0; c <= last + LAT + 5; c++) begin
            @(negedge clk);
            mic_a = (c >= ta) && !(glitch && c >= ta + 5 && c < ta + 10);
            mic_b = (tb >= 0) && (c >= tb);
            sample(c);
        end
        @(negedge clk);
        mic_a = 1'b0; mic_b = 1'b0;
        sample(c);
        wait_idle(c + 1);
        chk({tag, "_pulses"}, npulse, exp_v ? 1 : 0);
        chk({tag, "_b2b"}, ncons, 0);
        chk({tag, "_busy_len"}, busy_n, busy_exp);
        if (exp_v) begin
            chk({tag, "_cntr"}, pcntr, d);
            chk({tag, "_first_b"}, pfb, (tb >= 0 && tb < ta) ? 1 : 0);
            chk({tag, "_latency"}, pcyc, last + LAT);
            chk({tag, "_cntr_held"}, cntr, d);
        end else begin
            chk({tag, "_cntr_held"}, cntr, cntr_before);
        end
    endtask

    initial begin
        int c, d;
        rst = 1'b1; mic_a = 1'b0; mic_b = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_cntr", cntr, 0);
        chk("rst_valid", cntr_valid, 0);
        chk("rst_first_b", first_b, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        run("a_then_b_200", 0, 200, 1'b0);
        run("b_then_a_800", 800, 0, 1'b0);
        run("a_only_timeout", 0, -1, 1'b0);
        run("both_same_cycle", 0, 0, 1'b1);
        run("edge_at_max", 0, 1000, 1'b0);
        run("just_past_max", 0, 1001, 1'b0);
        run("b_first_at_max", 1000, 0, 1'b0);

        // Abort by reset mid-measurement; mic_a stays high across release.
        clear_stats();
        for (c = 0; c <= 120; c++) begin
            @(negedge clk);
            mic_a = 1'b1;
            mic_b = (c >= 100);
            rst   = (c == 50);
            sample(c);
            if (c == 51) begin
                chk("abort_cntr", cntr, 0);
                chk("abort_valid", cntr_valid, 0);
                chk("abort_first_b", first_b, 0);
                chk("abort_busy", busy, 0);
            end
        end
        @(negedge clk);
        mic_a = 1'b0; mic_b = 1'b0;
        wait_idle(c + 1);
        chk("abort_pulses", npulse, 0);
        run("after_abort", 0, 37, 1'b0);

        for (int t = 0; t < 6; t++) begin
            d = $urandom_range(0, 1100);
            if ($urandom_range(0, 1) == 1) run("rand_a_first", 0, d, 1'b0);
            else                           run("rand_b_first", d, 0, 1'b0);
        end

`ifdef TDOA_GLITCH_FILTER_EN
        clear_stats();
        for (c = 0; c < 30; c++) begin
            @(negedge clk);
            mic_a = (c >= 2 && c < 4);
            sample(c);
        end
        chk("glitch_busy", busy_n, 0);
        chk("glitch_pulses", npulse, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
